// File: rtl/ai_i2s_pkg.sv
// Shared constants, types and helpers for the I2S receive path.
package ai_i2s_pkg;

   localparam int RES_MIN     = 16;
   localparam int RES_MAX     = 32;
   localparam int RES_DEFAULT = 16;
   localparam int CNT_W       = 6;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      RECV
   } rx_state_e;

   typedef struct packed {
      logic               chan;
      logic [RES_MAX-1:0] data;
   } rx_entry_t;

   // Out-of-range resolutions fall back to the 16-bit default.
   function automatic logic [CNT_W-1:0] res_decode(input logic [CNT_W-1:0] res);
      if (res >= CNT_W'(RES_MIN) && res <= CNT_W'(RES_MAX)) begin
         return res;
      end
      return CNT_W'(RES_DEFAULT);
   endfunction

endpackage

// File: rtl/ai_i2s_bit_deserializer.sv
// Qualified SCK edge detect, WS framing FSM and MSB-first sample assembly.
module ai_i2s_bit_deserializer
   import ai_i2s_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_en_i,
   input  logic [CNT_W-1:0]   resolution_i,
   input  logic               rswap_i,
   input  logic               clk_en_i,
   input  logic               sck_i,
   input  logic               ws_i,
   input  logic               sd_i,
   output logic               word_valid_o,
   output logic [RES_MAX-1:0] word_o,
   output logic               chan_o,
   output logic               frame_err_o
);

   rx_state_e          state_q;
   logic               sck_q;
   logic               ws_prev_q;
   logic               chan_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   res_q, res_eff;
   logic [RES_MAX-1:0] shift_q, shift_d;
   logic               bit_stb;

   assign bit_stb = clk_en_i & sck_i & ~sck_q;

   // The first bit of a channel uses the live resolution; later bits use the latched copy.
   always_comb begin
      res_eff = (cnt_q == '0) ? res_decode(resolution_i) : res_q;
      cnt_d   = (cnt_q == CNT_W'(RES_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
      shift_d = (cnt_q < res_eff) ? {shift_q[RES_MAX-2:0], sd_i} : shift_q;
   end

   // NOTE: every register here uses <= so all of them sample pre-edge values; = is only for always_comb.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sck_q        <= 1'b0;
         ws_prev_q    <= 1'b0;
         chan_q       <= 1'b0;
         cnt_q        <= '0;
         res_q        <= CNT_W'(RES_DEFAULT);
         shift_q      <= '0;
         word_valid_o <= 1'b0;
         word_o       <= '0;
         chan_o       <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         sck_q        <= sck_i;
         word_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         if (!rx_en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
         end else if (bit_stb) begin
            ws_prev_q <= ws_i;
            case (state_q)
               IDLE: state_q <= SYNC;
               SYNC: begin
                  if (ws_i != ws_prev_q) begin
                     state_q <= RECV;
                     chan_q  <= ws_i ^ rswap_i;
                     cnt_q   <= '0;
                     shift_q <= '0;
                  end
               end
               RECV: begin
                  if (cnt_q == '0) begin
                     res_q <= res_decode(resolution_i);
                  end
                  if (ws_i != ws_prev_q) begin
                     // This edge carries the last bit of the outgoing channel.
                     if (cnt_d >= res_eff) begin
                        word_valid_o <= 1'b1;
                        word_o       <= shift_d;
                        chan_o       <= chan_q;
                     end else begin
                        frame_err_o <= 1'b1;
                     end
                     chan_q  <= ws_i ^ rswap_i;
                     cnt_q   <= '0;
                     shift_q <= '0;
                  end else begin
                     cnt_q   <= cnt_d;
                     shift_q <= shift_d;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ai_i2s_rx_block.sv
// I2S receiver: bit deserializer feeding a show-ahead sample FIFO with sticky error flags.
module ai_i2s_rx_block
   import ai_i2s_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_en,
   input  logic [5:0]            resolution,
   input  logic                  rswap,
   input  logic                  clk_en,
   input  logic                  sck,
   input  logic                  ws,
   input  logic                  sd,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_chan,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  overflow,
   output logic                  frame_err,
   input  logic                  err_clr
);

   localparam int              PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic               word_valid;
   logic               word_chan;
   logic [RES_MAX-1:0] word;
   logic               ferr_pulse;

   rx_entry_t          mem_q [FIFO_DEPTH];
   rx_entry_t          head;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               frame_err_q, frame_err_d;
   logic               empty, full, do_push, do_pop;

   ai_i2s_bit_deserializer u_deser (
      .clk          (clk),
      .rst          (rst),
      .rx_en_i      (rx_en),
      .resolution_i (resolution),
      .rswap_i      (rswap),
      .clk_en_i     (clk_en),
      .sck_i        (sck),
      .ws_i         (ws),
      .sd_i         (sd),
      .word_valid_o (word_valid),
      .word_o       (word),
      .chan_o       (word_chan),
      .frame_err_o  (ferr_pulse)
   );

   // A push into a full FIFO survives only when a pop frees the head in the same cycle.
   // NOTE: count_d gets its hold value first so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == DEPTH_CNT);
      do_pop   = rd_en & ~empty;
      do_push  = word_valid & (~full | rd_en);
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (PTR_W + 1)'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - (PTR_W + 1)'(1);
      end
      overflow_d  = (word_valid & full & ~rd_en) | (overflow_q & ~err_clr);
      frame_err_d = ferr_pulse | (frame_err_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   // NOTE: storage is deliberately not reset; the cleared count marks every entry invalid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= {word_chan, word};
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign rd_data    = empty ? '0 : DATA_WIDTH'(head.data);
   assign rd_chan    = empty ? 1'b0 : head.chan;
   assign fifo_empty = empty;
   assign fifo_full  = full;
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;

endmodule

// File: doc/ai_i2s_rx_block.md
Name: ai_i2s_rx_block

Overview:
I2S receive path, the counterpart of the TX block. Samples SD on qualified SCK rising edges and frames channels on WS transitions with the standard one-bit I2S delay. Assembles each channel sample MSB-first and pushes it, tagged with its channel, into a 16-deep show-ahead FIFO read by the register/DMA side. Reports overflow and short-frame errors through sticky flags.

Parameters:
DATA_WIDTH, 32, width of a received sample word (bits [actual_bits-1:0] carry the sample, upper bits zero)
FIFO_DEPTH, 16, receive FIFO entries (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  reset: one clock, synchronous, active-high
rx_en  in  1  receiver enable
resolution  in  6  bits per channel; valid 16..32, otherwise 16 is used
rswap  in  1  invert channel tag (swap L/R)
clk_en  in  1  qualifies SCK edge detection
sck  in  1  serial clock, synchronous to clk
ws  in  1  word select (0 = left, 1 = right)
sd  in  1  serial data
rd_en  in  1  pop FIFO head
rd_data  out  DATA_WIDTH  FIFO head sample, valid while !fifo_empty
rd_chan  out  1  FIFO head channel tag (0 = left)
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
overflow  out  1  sticky: sample dropped because FIFO full
frame_err  out  1  sticky: short channel dropped
err_clr  in  1  clears overflow and frame_err

Behaviour:
- Reset: all outputs 0 except fifo_empty=1; FSM to IDLE; FIFO pointers, count, shift register and bit counter cleared.
- sck_q registers sck. bit_stb = clk_en & sck & ~sck_q. Edges with clk_en=0 are ignored.
- actual_bits = resolution if 16..32, else 16. Latched at the first bit of each channel.
- FSM IDLE: rx_en=0, no sampling. rx_en=1 -> SYNC and capture ws into ws_prev at the next bit_stb.
- SYNC: on bit_stb with ws != ws_prev -> RECV. The channel is ws (xor rswap), bit count is 0, and the first bit arrives on the next bit_stb. The partial channel before this edge is discarded without setting an error.
- RECV, each bit_stb:
  - If ws == ws_prev: shift sd in at the LSB while count < actual_bits. Extra bits are ignored; count saturates at 32.
  - If ws != ws_prev: this bit is the previous channel's final bit and is shifted in under the same rule. The channel is then committed, and a new channel starts with the new ws.
- Commit:
  - If bits received == actual_bits: push {chan, word} with word zero-extended to DATA_WIDTH.
  - If bits received < actual_bits: drop the word and set frame_err.
- rx_en deassert in any state -> IDLE next cycle. The in-progress channel is dropped with no error. FIFO contents are kept.
- Latency: commit on bit_stb at cycle N -> FIFO write at the N+1 edge -> fifo_empty=0, rd_data/rd_chan valid in cycle N+2.
- FIFO behaviour:
  - Show-ahead.
  - rd_en while empty is ignored.
  - A push while full is accepted only if rd_en is high in the same cycle (simultaneous pop/push, count unchanged). Otherwise the push is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH. fifo_full is asserted when count == FIFO_DEPTH.
- Sticky flags: set has priority over err_clr in the same cycle.

Decomposition:
- Package ai_i2s_pkg holds:
  - RES_MIN=16, RES_MAX=32, RES_DEFAULT=16
  - typedef rx_state_e {IDLE, SYNC, RECV}
  - typedef rx_entry_t {chan, data}
- One sub-module, ai_i2s_bit_deserializer:
  - Contains the edge detect, FSM, shift register, bit counter and commit/frame_err generation.
  - Outputs word_valid, word, chan.
- The FIFO is implemented inline in ai_i2s_rx_block, using the synchronous active-high reset.

Test Plan:
- Basic: resolution=16, rx_en=1. Send a dummy left frame, then right=0xA5C3, then left=0x1234. Expected: FIFO holds {1,0x0000A5C3} then {0,0x00001234}; rd_chan 1 then 0; frame_err=0.
- Resolution 24: send left=0xABCDEF with 32 SCK per channel. Expected: rd_data=0x00ABCDEF; trailing 8 bits ignored. Resolution 7: 16-bit capture is used.
- Short frame: resolution=32, WS toggles after 20 bits. Expected: word dropped, frame_err=1 until err_clr; the next full frame is stored.
- Overflow: push 17 channels with rd_en=0. Expected: fifo_full after 16, 17th dropped, overflow=1. Repeat with rd_en=1 on the 17th commit cycle: accepted, overflow=0.
- rswap=1: send left=0x1111. Expected: rd_chan=1. Also check latency: fifo_empty falls exactly 2 clk after the committing bit_stb.
- Mid-operation: deassert rx_en mid-channel, then pulse rst mid-frame. Expected: partial channel dropped with no flags. After rst: fifo_empty=1, all flags 0, FSM resyncs (first channel discarded).
